// File: rtl/ebpc_encoder_frontend_p_if.sv
// Signal bundle for the EBPC encoder front-end: the input word stream, the
// flag and value output streams, and the per-frame status outputs.
interface ebpc_encoder_frontend_p_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              bypass_i;
  logic [DATA_W-1:0] data_i;
  logic              last_i;
  logic              vld_i;
  logic              rdy_o;
  logic              idle_o;
  logic              flag_o;
  logic              flag_last_o;
  logic              flag_vld_o;
  logic              flag_rdy_i;
  logic [DATA_W-1:0] val_data_o;
  logic              val_last_o;
  logic              val_vld_o;
  logic              val_rdy_i;
  logic [CNT_W-1:0]  frame_words_o;
  logic [CNT_W-1:0]  frame_nz_o;
  logic              frame_done_o;

  modport master (
    output bypass_i, data_i, last_i, vld_i, flag_rdy_i, val_rdy_i,
    input  rdy_o, idle_o, flag_o, flag_last_o, flag_vld_o,
           val_data_o, val_last_o, val_vld_o,
           frame_words_o, frame_nz_o, frame_done_o
  );

  modport slave (
    input  bypass_i, data_i, last_i, vld_i, flag_rdy_i, val_rdy_i,
    output rdy_o, idle_o, flag_o, flag_last_o, flag_vld_o,
           val_data_o, val_last_o, val_vld_o,
           frame_words_o, frame_nz_o, frame_done_o
  );
endinterface

// File: rtl/ebpc_encoder_frontend_p.sv
// EBPC encoder front-end: splits words into a zero/nonzero flag stream and a
// block-padded nonzero value stream, each behind its own FWFT FIFO.
module ebpc_encoder_frontend_p_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // Data is forced to zero when empty so nothing stale shows on the bus.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module ebpc_encoder_frontend_p #(
  parameter int DATA_W     = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  ebpc_encoder_frontend_p_if.slave bus
);
  localparam int                BLK_W    = $clog2(BLOCK_SIZE);
  localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {RUN, TAIL, PAD} state_e;

  state_e            state_q, state_d;
  logic              in_frame_q, in_frame_d;
  logic              bypass_q, bypass_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0]  words_q, words_d, nz_q, nz_d;
  logic              done_q, done_d;

  logic              flag_push, flag_full, flag_empty;
  logic [1:0]        flag_wdata, flag_rdata;
  logic              val_push, val_full, val_empty;
  logic [DATA_W:0]   val_wdata, val_rdata;
  logic              accept, frame_bypass, word_nz, blk_end;

  // Mode is latched on the first word, so later bypass_i changes are ignored.
  assign frame_bypass = in_frame_q ? bypass_q : bus.bypass_i;
  assign word_nz      = (bus.data_i != '0);
  assign blk_end      = (blk_cnt_q == BLK_LAST);
  assign bus.rdy_o    = rst_ni && (state_q == RUN) && !flag_full && !val_full;
  assign accept       = bus.vld_i && bus.rdy_o;

  always_comb begin
    state_d    = state_q;
    in_frame_d = in_frame_q;
    bypass_d   = bypass_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    blk_cnt_d  = blk_cnt_q;
    words_d    = words_q;
    nz_d       = nz_q;
    done_d     = 1'b0;
    flag_push  = 1'b0;
    flag_wdata = {word_nz, bus.last_i};
    val_push   = 1'b0;
    val_wdata  = {1'b0, hold_q};
    unique case (state_q)
      RUN: begin
        if (accept) begin
          in_frame_d = !bus.last_i;
          bypass_d   = frame_bypass;
          if (!in_frame_q) begin
            words_d = CNT_W'(1);
            nz_d    = CNT_W'(word_nz);
          end else begin
            if (words_q != '1) words_d = words_q + CNT_W'(1);
            if (word_nz && (nz_q != '1)) nz_d = nz_q + CNT_W'(1);
          end
          if (frame_bypass) begin
            val_push  = 1'b1;
            val_wdata = {bus.last_i, bus.data_i};
            done_d    = bus.last_i;
          end else begin
            flag_push = 1'b1;
            // The previous nonzero value is only released once a newer one arrives,
            // so the true last value can still be tagged at frame end.
            if (word_nz) begin
              if (hold_vld_q) begin
                val_push  = 1'b1;
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
              end
              hold_d     = bus.data_i;
              hold_vld_d = 1'b1;
            end
            if (bus.last_i) state_d = (word_nz || hold_vld_q) ? TAIL : PAD;
          end
        end
      end
      TAIL: begin
        if (!val_full) begin
          val_push   = 1'b1;
          val_wdata  = {blk_end, hold_q};
          hold_vld_d = 1'b0;
          if (blk_end) begin
            state_d   = RUN;
            done_d    = 1'b1;
            blk_cnt_d = '0;
          end else begin
            state_d   = PAD;
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
          end
        end
      end
      PAD: begin
        if (!val_full) begin
          val_push  = 1'b1;
          val_wdata = {blk_end, {DATA_W{1'b0}}};
          if (blk_end) begin
            state_d   = RUN;
            done_d    = 1'b1;
            blk_cnt_d = '0;
          end else begin
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      in_frame_q <= 1'b0;
      bypass_q   <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      blk_cnt_q  <= '0;
      words_q    <= '0;
      nz_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_frame_q <= in_frame_d;
      bypass_q   <= bypass_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      blk_cnt_q  <= blk_cnt_d;
      words_q    <= words_d;
      nz_q       <= nz_d;
      done_q     <= done_d;
    end
  end

  ebpc_encoder_frontend_p_fifo #(.WIDTH(2), .DEPTH(FIFO_DEPTH)) u_flag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (flag_push),
    .wdata_i (flag_wdata),
    .pop_i   (bus.flag_rdy_i),
    .rdata_o (flag_rdata),
    .full_o  (flag_full),
    .empty_o (flag_empty)
  );

  ebpc_encoder_frontend_p_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_val_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (val_push),
    .wdata_i (val_wdata),
    .pop_i   (bus.val_rdy_i),
    .rdata_o (val_rdata),
    .full_o  (val_full),
    .empty_o (val_empty)
  );

  assign bus.flag_o        = flag_rdata[1];
  assign bus.flag_last_o   = flag_rdata[0];
  assign bus.flag_vld_o    = !flag_empty;
  assign bus.val_data_o    = val_rdata[DATA_W-1:0];
  assign bus.val_last_o    = val_rdata[DATA_W];
  assign bus.val_vld_o     = !val_empty;
  assign bus.frame_words_o = words_q;
  assign bus.frame_nz_o    = nz_q;
  assign bus.frame_done_o  = done_q;
  assign bus.idle_o        = rst_ni && (state_q == RUN) && !in_frame_q && !hold_vld_q
                             && flag_empty && val_empty;
endmodule

// File: tb/tb_ebpc_encoder_frontend_p.sv
// Bench for ebpc_encoder_frontend_p: directed and random frames scored against
// a queue-based model of the flag and block-padded value streams.
module tb_ebpc_encoder_frontend_p;
  localparam int DATA_W     = 8;
  localparam int BLOCK_SIZE = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  ebpc_encoder_frontend_p_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  ebpc_encoder_frontend_p #(
    .DATA_W(DATA_W), .BLOCK_SIZE(BLOCK_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [DATA_W-1:0] frame_q[$];
  logic [1:0]        exp_flag[$];
  logic [DATA_W:0]   exp_val[$];
  int  exp_words, exp_nz, exp_lat;

  bit  rand_bp = 0;
  bit  acc_now = 0;
  bit  prev_done = 0;
  bit  rdy_at_stall_end = 1;
  int  stall_left = 0, stall_acc = 0, stall_flag_pops = 0;
  int  done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample handshakes just before the edge, advance, settle.
  task automatic tick();
    logic [1:0]      fe;
    logic [DATA_W:0] ve;
    if (rand_bp) begin
      bus.flag_rdy_i = 1'($urandom_range(0, 1));
      bus.val_rdy_i  = ($urandom_range(0, 3) != 0);
    end
    if (stall_left > 0) bus.val_rdy_i = 1'b0;
    #1;
    acc_now = bus.vld_i && bus.rdy_o;
    if (bus.flag_vld_o && bus.flag_rdy_i) begin
      check("flag_avail", 32'(exp_flag.size() != 0), 32'd1);
      if (exp_flag.size() != 0) begin
        fe = exp_flag.pop_front();
        check("flag", {30'b0, bus.flag_o, bus.flag_last_o}, {30'b0, fe});
      end
      if (stall_left > 0) stall_flag_pops++;
    end
    if (bus.val_vld_o && bus.val_rdy_i) begin
      check("val_avail", 32'(exp_val.size() != 0), 32'd1);
      if (exp_val.size() != 0) begin
        ve = exp_val.pop_front();
        check("val", 32'({bus.val_last_o, bus.val_data_o}), 32'(ve));
      end
    end
    if (bus.frame_done_o) begin
      check("done_width", 32'(prev_done), 32'd0);
      done_cnt++;
      done_cyc = cyc;
    end
    prev_done = bus.frame_done_o;
    if (acc_now) begin
      last_acc_cyc = cyc;
      if (stall_left > 0) stall_acc++;
    end
    if (stall_left == 1) rdy_at_stall_end = bus.rdy_o;
    @(posedge clk_i);
    #1;
    cyc++;
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) bus.val_rdy_i = 1'b1;
    end
  endtask

  // Expected streams for the frame in frame_q: flags per word, values are the
  // nonzero words padded with zeros to whole blocks (one block if none).
  task automatic model_frame(input bit byp);
    logic [DATA_W-1:0] v[$];
    int n;
    n = frame_q.size();
    exp_words = n;
    exp_nz = 0;
    foreach (frame_q[i]) if (frame_q[i] != 0) begin
      exp_nz++;
      v.push_back(frame_q[i]);
    end
    if (byp) begin
      foreach (frame_q[i]) exp_val.push_back({i == n - 1, frame_q[i]});
      exp_lat = 1;
    end else begin
      foreach (frame_q[i]) exp_flag.push_back({frame_q[i] != 0, i == n - 1});
      while (v.size() == 0 || (v.size() % BLOCK_SIZE) != 0) v.push_back('0);
      exp_lat = (exp_nz == 0) ? BLOCK_SIZE + 1 : v.size() - (exp_nz - 1) + 1;
      foreach (v[i]) exp_val.push_back({i == v.size() - 1, v[i]});
    end
  endtask

  task automatic drive_frame(input bit byp, input bit toggle, input bit gaps);
    int n, bound;
    n = frame_q.size();
    done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      bus.bypass_i = (i == 0) ? byp : (toggle ? ~byp : byp);
      bus.data_i   = frame_q[i];
      bus.last_i   = (i == n - 1);
      bus.vld_i    = 1'b1;
      bound = 0;
      do begin
        tick();
        bound++;
      end while (!acc_now && bound < 200);
      if (!acc_now) check("accept_timeout", 32'(acc_now), 32'd1);
      bus.vld_i  = 1'b0;
      bus.data_i = 8'($urandom);
      bus.last_i = 1'($urandom);
    end
  endtask

  task automatic finish_frame();
    int bound;
    bound = 0;
    while (done_cnt == 0 && bound < 300) begin
      tick();
      bound++;
    end
    check("done_count", 32'(done_cnt), 32'd1);
    if (!rand_bp) check("done_latency", 32'(done_cyc - last_acc_cyc), 32'(exp_lat));
    check("frame_words", 32'(bus.frame_words_o), 32'(exp_words));
    check("frame_nz", 32'(bus.frame_nz_o), 32'(exp_nz));
    bound = 0;
    while ((exp_flag.size() != 0 || exp_val.size() != 0) && bound < 300) begin
      tick();
      bound++;
    end
    check("flag_drained", 32'(exp_flag.size()), 32'd0);
    check("val_drained", 32'(exp_val.size()), 32'd0);
    if (!rand_bp) check("idle_after_frame", 32'(bus.idle_o), 32'd1);
  endtask

  task automatic send_frame(input bit byp, input bit toggle, input bit gaps);
    model_frame(byp);
    drive_frame(byp, toggle, gaps);
    finish_frame();
  endtask

  initial begin
    int  len;
    bit  byp;
    bus.bypass_i = 1'b0;
    bus.data_i = '0;
    bus.last_i = 1'b0;
    bus.vld_i = 1'b0;
    bus.flag_rdy_i = 1'b1;
    bus.val_rdy_i = 1'b1;

    // Reset values while held and right after release
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_rdy", 32'(bus.rdy_o), 32'd0);
    check("rst_idle", 32'(bus.idle_o), 32'd0);
    check("rst_flag_vld", 32'(bus.flag_vld_o), 32'd0);
    check("rst_val_vld", 32'(bus.val_vld_o), 32'd0);
    check("rst_done", 32'(bus.frame_done_o), 32'd0);
    rst_ni = 1'b1;
    #1;
    check("rel_rdy", 32'(bus.rdy_o), 32'd1);
    check("rel_idle", 32'(bus.idle_o), 32'd1);
    check("rel_words", 32'(bus.frame_words_o), 32'd0);
    check("rel_nz", 32'(bus.frame_nz_o), 32'd0);

    // Directed frames with both outputs always ready
    frame_q = '{8'd5, 8'd0, 8'd7, 8'd0, 8'd9};
    send_frame(1'b0, 1'b0, 1'b0);
    frame_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    send_frame(1'b0, 1'b0, 1'b0);
    frame_q = '{8'd0, 8'd0, 8'd0};
    send_frame(1'b0, 1'b0, 1'b0);

    // Value side stalled for 20 cycles while 8 nonzero words are offered
    frame_q = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
    model_frame(1'b0);
    stall_left = 20;
    stall_acc = 0;
    stall_flag_pops = 0;
    bus.val_rdy_i = 1'b0;
    drive_frame(1'b0, 1'b0, 1'b0);
    check("stall_accepted", 32'(stall_acc), 32'(FIFO_DEPTH + 1));
    check("stall_flag_pops", 32'(stall_flag_pops), 32'(FIFO_DEPTH + 1));
    check("stall_rdy_low", 32'(rdy_at_stall_end), 32'd0);
    finish_frame();

    // Bypass frame with bypass_i toggled mid-frame, then a normal frame
    frame_q = '{8'd0, 8'd3, 8'd0};
    send_frame(1'b1, 1'b1, 1'b0);
    frame_q = '{8'd0, 8'd6};
    send_frame(1'b0, 1'b0, 1'b0);

    // Random frames, the later ones with random backpressure on both outputs
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 12);
      byp = ($urandom_range(0, 3) == 0);
      frame_q.delete();
      for (int k = 0; k < len; k++)
        frame_q.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
      rand_bp = (f >= 10);
      send_frame(byp, 1'($urandom_range(0, 1)), 1'b1);
    end
    rand_bp = 1'b0;
    bus.flag_rdy_i = 1'b1;
    bus.val_rdy_i = 1'b1;
    repeat (4) tick();

    // Reset asserted while padding
    frame_q = '{8'd3};
    exp_flag.push_back(2'b11);
    exp_val.push_back({1'b0, 8'd3});
    drive_frame(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    check("prst_flag_vld", 32'(bus.flag_vld_o), 32'd0);
    check("prst_val_vld", 32'(bus.val_vld_o), 32'd0);
    check("prst_rdy", 32'(bus.rdy_o), 32'd0);
    check("prst_done", 32'(bus.frame_done_o), 32'd0);
    check("prst_queues", 32'(exp_flag.size() + exp_val.size()), 32'd0);
    exp_flag.delete();
    exp_val.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
    check("prel_idle", 32'(bus.idle_o), 32'd1);
    check("prel_rdy", 32'(bus.rdy_o), 32'd1);
    check("prel_words", 32'(bus.frame_words_o), 32'd0);
    check("prel_nz", 32'(bus.frame_nz_o), 32'd0);
    check("prel_val_vld", 32'(bus.val_vld_o), 32'd0);
    repeat (BLOCK_SIZE + 2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
